memory_responder: RTL and testbench

//  Responder for the controller's memory-side requests: instruction fetch and data load/store.

---
 rtl/memory_pkg.sv | 18 +
 rtl/memory_mmio_port.sv | 30 +++
 rtl/memory_responder.sv | 143 ++++++++++++++
 tb/tb_memory_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for the memory responder
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    localparam logic [15:0] MMIO_BASE = 16'hFFF0;

endpackage

// File: rtl/memory_mmio_port.sv
// rtl/memory_mmio_port.sv - 16-entry register file; entry 0 drives io_out, entry 'hF reads io_in
module memory_mmio_port #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [3:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [DATA_WIDTH-1:0] io_out
);

    logic [DATA_WIDTH-1:0] regs [16];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[addr] <= wdata;
        end
    end

    assign rdata  = (addr == 4'hF) ? io_in : regs[addr];
    assign io_out = regs[0];

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - serialises fetch and load/store requests onto one synchronous RAM port
// Optional MMIO register window: MEMORY_RESPONDER_MMIO_EN
module memory_responder
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifetch_req,
    input  logic [ADDR_WIDTH-1:0] ifetch_addr,
    output logic                  ifetch_ready,
    output logic                  ifetch_valid,
    output logic [DATA_WIDTH-1:0] ifetch_data,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ready,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_rdata,
`ifdef MEMORY_RESPONDER_MMIO_EN
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [DATA_WIDTH-1:0] io_out,
`endif
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    state_t                state, state_nx;
    owner_t                owner;
    logic                  is_we;
    logic                  is_mmio;
    logic [CW-1:0]         cnt;
    logic                  mmio_hit;
    logic [DATA_WIDTH-1:0] mmio_rdata;

`ifdef MEMORY_RESPONDER_MMIO_EN
    localparam logic [ADDR_WIDTH-1:0] MMIO_ADDR = ADDR_WIDTH'(MMIO_BASE);

    assign mmio_hit = (data_addr >= MMIO_ADDR);

    // Address and write data are already latched onto the RAM-side registers, reuse them here
    memory_mmio_port #(.DATA_WIDTH(DATA_WIDTH)) u_mmio (
        .clock  (clock),
        .reset  (reset),
        .we     ((state == ISSUE) && is_mmio && is_we),
        .addr   (ram_addr[3:0]),
        .wdata  (ram_wdata),
        .rdata  (mmio_rdata),
        .io_in  (io_in),
        .io_out (io_out)
    );
`else
    assign mmio_hit   = 1'b0;
    assign mmio_rdata = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (data_req || ifetch_req) state_nx = ISSUE;
            ISSUE:   state_nx = (is_we || is_mmio) ? RESPOND : WAIT;
            WAIT:    if (cnt == '0) state_nx = RESPOND;
            RESPOND: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ifetch_ready = (state == IDLE);
        data_ready   = (state == IDLE);
        ifetch_valid = (state == RESPOND) && (owner == OWNER_FETCH);
        data_valid   = (state == RESPOND) && (owner == OWNER_DATA);
        ram_we       = (state == ISSUE) && is_we && !is_mmio;
    end

    // Data port wins arbitration; the controller never issues data requests back to back
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner       <= OWNER_FETCH;
            is_we       <= 1'b0;
            is_mmio     <= 1'b0;
            cnt         <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ifetch_data <= '0;
            data_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        owner     <= OWNER_DATA;
                        is_we     <= data_we;
                        is_mmio   <= mmio_hit;
                        ram_addr  <= data_addr;
                        ram_wdata <= data_wdata;
                    end else if (ifetch_req) begin
                        owner    <= OWNER_FETCH;
                        is_we    <= 1'b0;
                        is_mmio  <= 1'b0;
                        ram_addr <= ifetch_addr;
                    end
                end
                ISSUE: begin
                    cnt <= CW'(RAM_LATENCY - 1);
                    if (is_we) begin
                        data_rdata <= '0;
                    end else if (is_mmio) begin
                        data_rdata <= mmio_rdata;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (owner == OWNER_DATA) begin
                            data_rdata <= ram_rdata;
                        end else begin
                            ifetch_data <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed scoreboard bench for memory_responder
module tb_memory_responder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_ready, f_valid;
    logic [15:0] f_data;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [15:0] d_addr = '0, d_wdata = '0;
    logic        d_ready, d_valid;
    logic [15:0] d_rdata;
    logic [15:0] r_addr, r_wdata, r_rdata;
    logic        r_we;

    logic        f3_req = 1'b0;
    logic [15:0] f3_addr = '0;
    logic        f3_ready, f3_valid, d3_ready, d3_valid, r3_we;
    logic [15:0] f3_data, d3_rdata, r3_addr, r3_wdata, r3_rdata, p3a, p3b;

`ifdef MEMORY_RESPONDER_MMIO_EN
    logic [15:0] io_in = '0, io_in3 = '0;
    logic [15:0] io_out, io_out3;
`endif

    memory_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .ifetch_req(f_req), .ifetch_addr(f_addr), .ifetch_ready(f_ready),
        .ifetch_valid(f_valid), .ifetch_data(f_data),
        .data_req(d_req), .data_we(d_we), .data_addr(d_addr), .data_wdata(d_wdata),
        .data_ready(d_ready), .data_valid(d_valid), .data_rdata(d_rdata),
`ifdef MEMORY_RESPONDER_MMIO_EN
        .io_in(io_in), .io_out(io_out),
`endif
        .ram_addr(r_addr), .ram_we(r_we), .ram_wdata(r_wdata), .ram_rdata(r_rdata)
    );

    memory_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .ifetch_req(f3_req), .ifetch_addr(f3_addr), .ifetch_ready(f3_ready),
        .ifetch_valid(f3_valid), .ifetch_data(f3_data),
        .data_req(1'b0), .data_we(1'b0), .data_addr(16'h0000), .data_wdata(16'h0000),
        .data_ready(d3_ready), .data_valid(d3_valid), .data_rdata(d3_rdata),
`ifdef MEMORY_RESPONDER_MMIO_EN
        .io_in(io_in3), .io_out(io_out3),
`endif
        .ram_addr(r3_addr), .ram_we(r3_we), .ram_wdata(r3_wdata), .ram_rdata(r3_rdata)
    );

    // RAM models: 1-cycle and 3-cycle read latency, with a bench-side preload port
    logic [15:0] mem1 [1024];
    logic [15:0] mem3 [1024];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clock) begin
        if (pl_we) begin
            mem1[pl_addr] <= pl_data;
            mem3[pl_addr] <= pl_data;
        end
        if (r_we)  mem1[r_addr[9:0]]  <= r_wdata;
        if (r3_we) mem3[r3_addr[9:0]] <= r3_wdata;
        r_rdata  <= mem1[r_addr[9:0]];
        p3a      <= mem3[r3_addr[9:0]];
        p3b      <= p3a;
        r3_rdata <= p3b;
    end

    logic [15:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(negedge clock);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_we = 1'b0;
    endtask

    // Called one negedge before the accepting posedge; returns at the negedge of the valid cycle
    task automatic wait_resp(input bit is_data, input int lat, input int we_exp, input string tag);
        int n = 0, we_cnt = 0;
        bit rdy_seen = 0, got = 0, wrong = 0;
        logic [15:0] dat = '0;
        while (n < 12 && !got) begin
            @(negedge clock);
            n++;
            if (f_ready || d_ready) rdy_seen = 1;
            if (r_we) we_cnt++;
            if (is_data ? f_valid : d_valid) wrong = 1;
            if (is_data ? d_valid : f_valid) begin
                got = 1;
                dat = is_data ? d_rdata : f_data;
            end
        end
        check({tag, " valid"}, got, 1);
        check({tag, " latency"}, n, lat);
        check({tag, " readies_low"}, rdy_seen, 0);
        check({tag, " ram_we_cycles"}, we_cnt, we_exp);
        check({tag, " other_port_valid"}, wrong, 0);
        if (got && exp_q.size() > 0) check({tag, " data"}, dat, exp_q.pop_front());
        if (is_data) d_req = 1'b0; else f_req = 1'b0;
    endtask

    task automatic issue(input bit is_data, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp,
                         input int lat, input int we_exp, input string tag);
        @(negedge clock);
        check({tag, " ready"}, is_data ? d_ready : f_ready, 1);
        exp_q.push_back(exp);
        if (is_data) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        wait_resp(is_data, lat, we_exp, tag);
    endtask

    initial begin
        int n;
        bit rdy, got, seen;

        preload(10'h010, 16'hD105);
        preload(10'h011, 16'hA011);
        preload(10'h040, 16'h1234);
        preload(10'h000, 16'h3C3C);
        preload(10'h030, 16'h1111);
        preload(10'h3F0, 16'h5555);

        check("rst ifetch_ready", f_ready, 1);
        check("rst data_ready", d_ready, 1);
        check("rst ifetch_valid", f_valid, 0);
        check("rst data_valid", d_valid, 0);
        check("rst ram_we", r_we, 0);
        check("rst ram_addr", r_addr, 0);
        check("rst ram_wdata", r_wdata, 0);
        check("rst data_rdata", d_rdata, 0);
        check("rst ifetch_data", f_data, 0);
        check("rst lat3 ready", f3_ready, 1);
        @(negedge clock);
        reset = 1'b1;

        issue(0, 0, 16'h0010, 16'h0, 16'hD105, 3, 0, "fetch1");

        // Simultaneous requests: data first, fetch in the IDLE cycle after data_valid
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        f_req = 1'b1; f_addr = 16'h0011;
        exp_q.push_back(16'h1234);
        wait_resp(1, 3, 0, "arb_data");
        @(negedge clock);
        check("arb idle ifetch_ready", f_ready, 1);
        exp_q.push_back(16'hA011);
        wait_resp(0, 3, 0, "arb_fetch");
        @(negedge clock);
        check("ram_addr hold", r_addr, 16'h0011);
        check("ifetch_data hold", f_data, 16'hA011);

        issue(1, 1, 16'h0020, 16'hBEEF, 16'h0000, 2, 1, "store");
        check("store ram contents", mem1[10'h020], 16'hBEEF);
        issue(1, 0, 16'h0020, 16'h0, 16'hBEEF, 3, 0, "load_back");

        // RAM_LATENCY=3 fetch
        @(negedge clock);
        f3_req = 1'b1; f3_addr = 16'h0000;
        exp_q.push_back(16'h3C3C);
        n = 0; rdy = 0; got = 0;
        while (n < 12 && !got) begin
            @(negedge clock);
            n++;
            if (f3_ready || d3_ready) rdy = 1;
            if (f3_valid) got = 1;
        end
        f3_req = 1'b0;
        check("lat3 valid", got, 1);
        check("lat3 latency", n, 5);
        check("lat3 readies_low", rdy, 0);
        if (got) check("lat3 data", f3_data, exp_q.pop_front());

        // Reset during WAIT of a load drops the transaction
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        d_req = 1'b0;
        check("rstwait data_ready", d_ready, 1);
        check("rstwait ifetch_ready", f_ready, 1);
        check("rstwait ram_we", r_we, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (d_valid) seen = 1;
        end
        reset = 1'b1;
        @(negedge clock);
        if (d_valid) seen = 1;
        check("rstwait no valid", seen, 0);
        check("rstwait ready after", d_ready, 1);
        issue(1, 0, 16'h0040, 16'h0, 16'h1234, 3, 0, "load_after_rst");

        // Reset during a store's ISSUE cycle clears ram_we at once and blocks the write
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h7777;
        @(negedge clock);
        check("rststore ram_we before", r_we, 1);
        reset = 1'b0;
        #1;
        check("rststore ram_we cleared", r_we, 0);
        d_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rststore ram untouched", mem1[10'h030], 16'h1111);
        check("rststore no valid", d_valid, 0);

        issue(0, 0, 16'hFFF0, 16'h0, 16'h5555, 3, 0, "fetch_high");

`ifdef MEMORY_RESPONDER_MMIO_EN
        io_in = 16'h0F0F;
        issue(1, 1, 16'hFFF0, 16'h00A5, 16'h0000, 2, 0, "mmio_store");
        check("mmio io_out", io_out, 16'h00A5);
        check("mmio ram untouched", mem1[10'h3F0], 16'h5555);
        issue(1, 0, 16'hFFFF, 16'h0, 16'h0F0F, 2, 0, "mmio_io_in");
        issue(1, 0, 16'hFFF0, 16'h0, 16'h00A5, 2, 0, "mmio_reg0");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
